// File: rtl/rotate_pkg.sv
// Shared types and defaults for the rotate job controller.
// Job record: width, height, direction, degrees (35 bits).
package rotate_pkg;

    localparam int QUEUE_DEPTH_DEFAULT = 4;
    localparam int ACK_TIMEOUT_DEFAULT = 16;

    localparam int DIM_W = 16;
    localparam int DEG_W = 2;
    localparam int JOB_W = 2 * DIM_W + 1 + DEG_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_ACK,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DIM_W-1:0] width;
        logic [DIM_W-1:0] height;
        logic             direction;
        logic [DEG_W-1:0] degrees;
    } job_t;

endpackage

// File: rtl/rotate_job_fifo.sv
// Synchronous job FIFO with registered storage and occupancy count.
// A pop never frees space for a push in the same cycle.
module rotate_job_fifo
    import rotate_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int WIDTH = JOB_W
) (
    input  logic                   I_HCLK,
    input  logic                   I_HRESET_N,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge I_HCLK) begin
        if (!I_HRESET_N) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push)
                           - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/rotate_job_ctrl.sv
// Job queue and dispatch FSM in front of the rotate core.
// Config is latched on IDLE->LAUNCH and held until the next launch.
module rotate_job_ctrl
    import rotate_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                         I_HCLK,
    input  logic                         I_HRESET_N,
    input  logic                         I_JOB_VALID,
    output logic                         O_JOB_READY,
    input  logic [15:0]                  I_JOB_WIDTH,
    input  logic [15:0]                  I_JOB_HEIGHT,
    input  logic                         I_JOB_DIRECTION,
    input  logic [1:0]                   I_JOB_DEGREES,
    input  logic                         I_ENABLE,
    input  logic                         I_IRQ_CLR,
    input  logic                         I_CORE_BUSY,
    output logic                         O_CORE_START,
    output logic [15:0]                  O_CORE_WIDTH,
    output logic [15:0]                  O_CORE_HEIGHT,
    output logic                         O_CORE_DIRECTION,
    output logic [1:0]                   O_CORE_DEGREES,
    output logic                         O_BUSY,
    output logic [$clog2(QUEUE_DEPTH):0] O_PENDING,
    output logic [7:0]                   O_DONE_COUNT,
    output logic                         O_IRQ,
    output logic                         O_ERR
);
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    state_t        state;
    state_t        state_nx;
    job_t          in_job;
    job_t          head;
    job_t          cfg;
    logic [TW-1:0] ack_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_acc;
    logic          zero_dim;
    logic          pop;
    logic          load;
    logic          timeout;
    logic          err_set;

    assign in_job = '{width:     I_JOB_WIDTH,
                      height:    I_JOB_HEIGHT,
                      direction: I_JOB_DIRECTION,
                      degrees:   I_JOB_DEGREES};

    assign O_JOB_READY = ~fifo_full;
    assign push_acc    = I_JOB_VALID & ~fifo_full;
    assign zero_dim    = (I_JOB_WIDTH == '0) | (I_JOB_HEIGHT == '0);
    assign pop         = (state == ST_DONE);
    assign err_set     = (push_acc & zero_dim) | timeout;

    rotate_job_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (JOB_W)
    ) u_fifo (
        .I_HCLK     (I_HCLK),
        .I_HRESET_N (I_HRESET_N),
        .push       (push_acc & ~zero_dim),
        .pop        (pop),
        .wdata      (in_job),
        .rdata      (head),
        .count      (O_PENDING),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_nx     = state;
        load         = 1'b0;
        timeout      = 1'b0;
        O_CORE_START = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty && I_ENABLE) begin
                    state_nx = ST_LAUNCH;
                    load     = 1'b1;
                end
            end
            ST_LAUNCH: begin
                O_CORE_START = 1'b1;
                state_nx     = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (I_CORE_BUSY) begin
                    state_nx = ST_RUN;
                end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    timeout  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_RUN: begin
                if (!I_CORE_BUSY) state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Set beats clear on both sticky flags.
    always_ff @(posedge I_HCLK) begin
        if (!I_HRESET_N) begin
            state        <= ST_IDLE;
            ack_cnt      <= '0;
            cfg          <= '0;
            O_DONE_COUNT <= '0;
            O_IRQ        <= 1'b0;
            O_ERR        <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_WAIT_ACK) ack_cnt <= ack_cnt + TW'(1);
            else                      ack_cnt <= '0;
            if (load) cfg <= head;
            if (pop) O_DONE_COUNT <= O_DONE_COUNT + 8'd1;
            if (pop)            O_IRQ <= 1'b1;
            else if (I_IRQ_CLR) O_IRQ <= 1'b0;
            if (err_set)        O_ERR <= 1'b1;
            else if (I_IRQ_CLR) O_ERR <= 1'b0;
        end
    end

    assign O_BUSY           = (state != ST_IDLE);
    assign O_CORE_WIDTH     = cfg.width;
    assign O_CORE_HEIGHT    = cfg.height;
    assign O_CORE_DIRECTION = cfg.direction;
    assign O_CORE_DEGREES   = cfg.degrees;

endmodule

// File: tb/tb_rotate_job_ctrl.sv
// Scenario bench for rotate_job_ctrl with a job scoreboard
// checked against the core config at every start pulse.
module tb_rotate_job_ctrl;
    import rotate_pkg::*;

    localparam int QD = 4;
    localparam int AT = 16;

    logic        I_HCLK = 1'b0;
    logic        I_HRESET_N = 1'b0;
    logic        I_JOB_VALID = 1'b0;
    logic        O_JOB_READY;
    logic [15:0] I_JOB_WIDTH = '0;
    logic [15:0] I_JOB_HEIGHT = '0;
    logic        I_JOB_DIRECTION = 1'b0;
    logic [1:0]  I_JOB_DEGREES = '0;
    logic        I_ENABLE = 1'b0;
    logic        I_IRQ_CLR = 1'b0;
    logic        I_CORE_BUSY = 1'b0;
    logic        O_CORE_START;
    logic [15:0] O_CORE_WIDTH;
    logic [15:0] O_CORE_HEIGHT;
    logic        O_CORE_DIRECTION;
    logic [1:0]  O_CORE_DEGREES;
    logic        O_BUSY;
    logic [2:0]  O_PENDING;
    logic [7:0]  O_DONE_COUNT;
    logic        O_IRQ;
    logic        O_ERR;

    int         errors = 0;
    int         checks = 0;
    job_t       sb[$];
    logic [7:0] exp_done = '0;

    always #5 I_HCLK = ~I_HCLK;

    rotate_job_ctrl #(
        .QUEUE_DEPTH (QD),
        .ACK_TIMEOUT (AT)
    ) dut (
        .I_HCLK           (I_HCLK),
        .I_HRESET_N       (I_HRESET_N),
        .I_JOB_VALID      (I_JOB_VALID),
        .O_JOB_READY      (O_JOB_READY),
        .I_JOB_WIDTH      (I_JOB_WIDTH),
        .I_JOB_HEIGHT     (I_JOB_HEIGHT),
        .I_JOB_DIRECTION  (I_JOB_DIRECTION),
        .I_JOB_DEGREES    (I_JOB_DEGREES),
        .I_ENABLE         (I_ENABLE),
        .I_IRQ_CLR        (I_IRQ_CLR),
        .I_CORE_BUSY      (I_CORE_BUSY),
        .O_CORE_START     (O_CORE_START),
        .O_CORE_WIDTH     (O_CORE_WIDTH),
        .O_CORE_HEIGHT    (O_CORE_HEIGHT),
        .O_CORE_DIRECTION (O_CORE_DIRECTION),
        .O_CORE_DEGREES   (O_CORE_DEGREES),
        .O_BUSY           (O_BUSY),
        .O_PENDING        (O_PENDING),
        .O_DONE_COUNT     (O_DONE_COUNT),
        .O_IRQ            (O_IRQ),
        .O_ERR            (O_ERR)
    );

    task automatic tick();
        @(posedge I_HCLK);
        #1;
    endtask

    function automatic job_t cfg_now();
        return {O_CORE_WIDTH, O_CORE_HEIGHT,
                O_CORE_DIRECTION, O_CORE_DEGREES};
    endfunction

    task automatic set_job(input logic [15:0] w, input logic [15:0] h,
                           input logic d, input logic [1:0] g);
        I_JOB_WIDTH     = w;
        I_JOB_HEIGHT    = h;
        I_JOB_DIRECTION = d;
        I_JOB_DEGREES   = g;
    endtask

    task automatic push_job(input logic [15:0] w, input logic [15:0] h,
                            input logic d, input logic [1:0] g);
        bit r;
        bit ok;
        ok = 1'b0;
        set_job(w, h, d, g);
        I_JOB_VALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            r = O_JOB_READY;
            tick();
            if (r) ok = 1'b1;
        end
        I_JOB_VALID = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_accept: ready=%0b required=1", O_JOB_READY);
        end else if (w != 0 && h != 0) begin
            sb.push_back('{width: w, height: h, direction: d, degrees: g});
        end
    endtask

    task automatic serve_job(input int ack_dly, input int run_len,
                             input bit clr);
        job_t exp;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (O_CORE_START === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || sb.size() == 0) begin
            errors++;
            $display("FAIL serve_start: start=%0b queued=%0d required start=1",
                     O_CORE_START, sb.size());
            return;
        end
        exp = sb.pop_front();
        checks++;
        if (cfg_now() !== exp) begin
            errors++;
            $display("FAIL launch_cfg: got=%h required=%h", cfg_now(), exp);
        end
        tick();
        checks++;
        if (O_CORE_START !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse: start=%0b required=0", O_CORE_START);
        end
        repeat (ack_dly) tick();
        I_CORE_BUSY = 1'b1;
        repeat (run_len) tick();
        I_CORE_BUSY = 1'b0;
        tick();
        checks++;
        if (cfg_now() !== exp) begin
            errors++;
            $display("FAIL cfg_hold: got=%h required=%h", cfg_now(), exp);
        end
        I_IRQ_CLR = clr;
        tick();
        I_IRQ_CLR = 1'b0;
        exp_done++;
        checks++;
        if (O_DONE_COUNT !== exp_done) begin
            errors++;
            $display("FAIL done_count: got=%0d required=%0d",
                     O_DONE_COUNT, exp_done);
        end
        checks++;
        if (O_IRQ !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got=%0b required=1", O_IRQ);
        end
    endtask

    task automatic test_reset();
        I_HRESET_N = 1'b0;
        tick();
        tick();
        checks++;
        if ({O_CORE_START, O_BUSY, O_PENDING, O_DONE_COUNT,
             O_IRQ, O_ERR, cfg_now()} !== '0) begin
            errors++;
            $display("FAIL reset_outs: start=%0b busy=%0b pend=%0d cnt=%0d irq=%0b err=%0b cfg=%h required all 0",
                     O_CORE_START, O_BUSY, O_PENDING, O_DONE_COUNT,
                     O_IRQ, O_ERR, cfg_now());
        end
        checks++;
        if (O_JOB_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got=%0b required=1", O_JOB_READY);
        end
        I_HRESET_N = 1'b1;
        tick();
    endtask

    task automatic test_single();
        job_t exp;
        bool_hold: begin end
        I_ENABLE = 1'b1;
        set_job(16'd8, 16'd8, 1'b0, 2'd0);
        I_JOB_VALID = 1'b1;
        tick();
        I_JOB_VALID = 1'b0;
        sb.push_back('{width: 16'd8, height: 16'd8,
                       direction: 1'b0, degrees: 2'd0});
        checks++;
        if (O_PENDING !== 3'd1 || O_CORE_START !== 1'b0) begin
            errors++;
            $display("FAIL push_edge: pend=%0d start=%0b required 1/0",
                     O_PENDING, O_CORE_START);
        end
        tick();
        checks++;
        if (O_CORE_START !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: start=%0b required=1", O_CORE_START);
        end
        exp = sb.pop_front();
        checks++;
        if (cfg_now() !== exp) begin
            errors++;
            $display("FAIL single_cfg: got=%h required=%h", cfg_now(), exp);
        end
        tick();
        checks++;
        if (O_CORE_START !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: start=%0b required=0", O_CORE_START);
        end
        tick();
        I_CORE_BUSY = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 20) I_ENABLE = 1'b0;
            tick();
            checks++;
            if (cfg_now() !== exp || O_BUSY !== 1'b1) begin
                errors++;
                $display("FAIL single_hold: cyc=%0d cfg=%h busy=%0b required %h/1",
                         i, cfg_now(), O_BUSY, exp);
            end
        end
        I_CORE_BUSY = 1'b0;
        tick();
        checks++;
        if (O_BUSY !== 1'b1 || O_DONE_COUNT !== 8'd0) begin
            errors++;
            $display("FAIL single_done: busy=%0b cnt=%0d required 1/0",
                     O_BUSY, O_DONE_COUNT);
        end
        tick();
        exp_done = 8'd1;
        checks++;
        if (O_DONE_COUNT !== 8'd1 || O_IRQ !== 1'b1 ||
            O_ERR !== 1'b0 || O_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL single_end: cnt=%0d irq=%0b err=%0b busy=%0b required 1/1/0/0",
                     O_DONE_COUNT, O_IRQ, O_ERR, O_BUSY);
        end
        push_job(16'd5, 16'd5, 1'b1, 2'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (O_CORE_START !== 1'b0 || O_PENDING !== 3'd1) begin
                errors++;
                $display("FAIL enable_block: start=%0b pend=%0d required 0/1",
                         O_CORE_START, O_PENDING);
            end
        end
        I_ENABLE = 1'b1;
        serve_job(0, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ws[4] = '{16'd62, 16'd123, 16'd32, 16'd17};
        logic [15:0] hs[4] = '{16'd63, 16'd5, 16'd24, 16'd9};
        job_t exp;
        int   seen;
        seen = 0;
        I_CORE_BUSY = 1'b1;
        I_JOB_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_job(ws[i], hs[i], i[0], i[1:0]);
            tick();
            sb.push_back('{width: ws[i], height: hs[i],
                           direction: i[0], degrees: i[1:0]});
            if (O_CORE_START === 1'b1) begin
                seen++;
                exp = sb.pop_front();
                checks++;
                if (cfg_now() !== exp) begin
                    errors++;
                    $display("FAIL b2b_first: got=%h required=%h",
                             cfg_now(), exp);
                end
            end
        end
        set_job(16'd200, 16'd300, 1'b1, 2'd2);
        checks++;
        if (O_JOB_READY !== 1'b0 || O_PENDING !== 3'd4) begin
            errors++;
            $display("FAIL b2b_full: ready=%0b pend=%0d required 0/4",
                     O_JOB_READY, O_PENDING);
        end
        repeat (3) tick();
        checks++;
        if (O_JOB_READY !== 1'b0 || O_PENDING !== 3'd4 || seen != 1) begin
            errors++;
            $display("FAIL b2b_held: ready=%0b pend=%0d starts=%0d required 0/4/1",
                     O_JOB_READY, O_PENDING, seen);
        end
        I_CORE_BUSY = 1'b0;
        tick();
        checks++;
        if (O_JOB_READY !== 1'b0 || O_PENDING !== 3'd4) begin
            errors++;
            $display("FAIL b2b_nobypass: ready=%0b pend=%0d required 0/4",
                     O_JOB_READY, O_PENDING);
        end
        tick();
        exp_done++;
        checks++;
        if (O_PENDING !== 3'd3 || O_JOB_READY !== 1'b1 ||
            O_DONE_COUNT !== exp_done) begin
            errors++;
            $display("FAIL b2b_pop: pend=%0d ready=%0b cnt=%0d required 3/1/%0d",
                     O_PENDING, O_JOB_READY, O_DONE_COUNT, exp_done);
        end
        tick();
        I_JOB_VALID = 1'b0;
        sb.push_back('{width: 16'd200, height: 16'd300,
                       direction: 1'b1, degrees: 2'd2});
        checks++;
        if (O_PENDING !== 3'd4) begin
            errors++;
            $display("FAIL b2b_fifth: pend=%0d required=4", O_PENDING);
        end
        for (int i = 0; i < 4; i++) serve_job(1, 2, 1'b0);
    endtask

    task automatic test_timeout();
        job_t exp;
        bit   seen;
        seen = 1'b0;
        I_IRQ_CLR = 1'b1;
        tick();
        I_IRQ_CLR = 1'b0;
        push_job(16'd40, 16'd30, 1'b0, 2'd1);
        push_job(16'd10, 16'd20, 1'b1, 2'd0);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (O_CORE_START === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL to_start: start=%0b required=1", O_CORE_START);
        end
        exp = sb.pop_front();
        checks++;
        if (cfg_now() !== exp) begin
            errors++;
            $display("FAIL to_cfg: got=%h required=%h", cfg_now(), exp);
        end
        repeat (AT) tick();
        checks++;
        if (O_ERR !== 1'b0 || O_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL to_early: err=%0b busy=%0b required 0/1",
                     O_ERR, O_BUSY);
        end
        tick();
        checks++;
        if (O_ERR !== 1'b1 || O_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL to_err: err=%0b busy=%0b required 1/1",
                     O_ERR, O_BUSY);
        end
        tick();
        exp_done++;
        checks++;
        if (O_DONE_COUNT !== exp_done || O_IRQ !== 1'b1 ||
            O_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL to_done: cnt=%0d irq=%0b busy=%0b required %0d/1/0",
                     O_DONE_COUNT, O_IRQ, O_BUSY, exp_done);
        end
        serve_job(2, 3, 1'b0);
    endtask

    task automatic test_zero();
        bit bad;
        bad = 1'b0;
        I_IRQ_CLR = 1'b1;
        tick();
        I_IRQ_CLR = 1'b0;
        push_job(16'd0, 16'd7, 1'b0, 2'd0);
        checks++;
        if (O_PENDING !== 3'd0 || O_ERR !== 1'b1 || O_JOB_READY !== 1'b1) begin
            errors++;
            $display("FAIL zero_push: pend=%0d err=%0b ready=%0b required 0/1/1",
                     O_PENDING, O_ERR, O_JOB_READY);
        end
        for (int i = 0; i < 5; i++) begin
            if (O_CORE_START !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL zero_nostart: start seen, required none");
        end
        I_IRQ_CLR = 1'b1;
        tick();
        I_IRQ_CLR = 1'b0;
        checks++;
        if (O_ERR !== 1'b0) begin
            errors++;
            $display("FAIL zero_clr: err=%0b required=0", O_ERR);
        end
        I_IRQ_CLR = 1'b1;
        push_job(16'd9, 16'd0, 1'b0, 2'd0);
        I_IRQ_CLR = 1'b0;
        checks++;
        if (O_ERR !== 1'b1 || O_PENDING !== 3'd0) begin
            errors++;
            $display("FAIL zero_setwins: err=%0b pend=%0d required 1/0",
                     O_ERR, O_PENDING);
        end
        I_IRQ_CLR = 1'b1;
        tick();
        I_IRQ_CLR = 1'b0;
    endtask

    task automatic test_reset_midjob();
        bit bad;
        bad = 1'b0;
        I_CORE_BUSY = 1'b1;
        push_job(16'd11, 16'd12, 1'b0, 2'd1);
        push_job(16'd13, 16'd14, 1'b1, 2'd2);
        push_job(16'd15, 16'd16, 1'b0, 2'd3);
        repeat (2) tick();
        checks++;
        if (O_BUSY !== 1'b1 || O_PENDING !== 3'd3) begin
            errors++;
            $display("FAIL mid_setup: busy=%0b pend=%0d required 1/3",
                     O_BUSY, O_PENDING);
        end
        I_HRESET_N = 1'b0;
        tick();
        checks++;
        if ({O_CORE_START, O_BUSY, O_PENDING, O_DONE_COUNT,
             O_IRQ, O_ERR, cfg_now()} !== '0 || O_JOB_READY !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: start=%0b busy=%0b pend=%0d cnt=%0d irq=%0b err=%0b ready=%0b required zeros, ready=1",
                     O_CORE_START, O_BUSY, O_PENDING, O_DONE_COUNT,
                     O_IRQ, O_ERR, O_JOB_READY);
        end
        I_HRESET_N = 1'b1;
        I_CORE_BUSY = 1'b0;
        sb.delete();
        exp_done = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (O_CORE_START !== 1'b0 || O_DONE_COUNT !== 8'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mid_quiet: start or count changed after reset");
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                I_IRQ_CLR = 1'b1;
                tick();
                I_IRQ_CLR = 1'b0;
                checks++;
                if (O_IRQ !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_clr: irq=%0b required=0", O_IRQ);
                end
            end
            push_job(16'($urandom_range(1, 65535)),
                     16'($urandom_range(1, 65535)),
                     1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)));
            serve_job(0, 1, i == 255);
        end
        checks++;
        if (O_DONE_COUNT !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero: cnt=%0d required=0", O_DONE_COUNT);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_zero();
        test_reset_midjob();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
